regfile_scoreboard: RTL and testbench

- Architectural integer register file: the consumer of the writeback port driven by the WB stage.
- Provides two combinational read ports to the decode stage.
- Per-register outstanding-write scoreboard: decode registers each issued destination; the WB write retires it.
- Generates the decode stall for RAW hazards and for saturated in-flight counts.

---
 rtl/regfile_scoreboard_pkg.sv | 28 ++
 rtl/regfile_scoreboard_if.sv | 46 ++++
 rtl/regfile_scoreboard_sb_counter_bank.sv | 48 ++++
 rtl/regfile_scoreboard.sv | 85 ++++++++
 tb/tb_regfile_scoreboard.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file types and constants for the decode/writeback slice.
// Optional build macro: RF_WB_BYPASS_EN (writeback-to-decode forwarding).
`ifndef RNG_WR_DATA_REG
`define RNG_WR_DATA_REG 31:0
`endif
`ifndef RNG_WR_ADDR_REG
`define RNG_WR_ADDR_REG 4:0
`endif

package regfile_scoreboard_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int CNTW  = 2;

  typedef logic [`RNG_WR_DATA_REG] reg_data_t;
  typedef logic [`RNG_WR_ADDR_REG] reg_addr_t;
  typedef logic [NREGS-1:0]        reg_vec_t;

  function automatic reg_vec_t onehot(reg_addr_t a);
    reg_vec_t v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle of the register file.
// master = pipeline side, slave = register file.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  reg_addr_t i_wb_wr_reg_addr;
  reg_data_t i_wb_wr_reg_data;
  logic      i_wb_wr_reg_en;
  reg_addr_t i_id_rs1_addr;
  reg_addr_t i_id_rs2_addr;
  logic      i_id_issue;
  reg_addr_t i_id_rd_addr;
  logic      i_flush;
  reg_data_t o_id_rs1_data;
  reg_data_t o_id_rs2_data;
  logic      o_id_stall;

  modport master (
    output i_wb_wr_reg_addr,
    output i_wb_wr_reg_data,
    output i_wb_wr_reg_en,
    output i_id_rs1_addr,
    output i_id_rs2_addr,
    output i_id_issue,
    output i_id_rd_addr,
    output i_flush,
    input  o_id_rs1_data,
    input  o_id_rs2_data,
    input  o_id_stall
  );

  modport slave (
    input  i_wb_wr_reg_addr,
    input  i_wb_wr_reg_data,
    input  i_wb_wr_reg_en,
    input  i_id_rs1_addr,
    input  i_id_rs2_addr,
    input  i_id_issue,
    input  i_id_rd_addr,
    input  i_flush,
    output o_id_rs1_data,
    output o_id_rs2_data,
    output o_id_stall
  );

endinterface

// File: rtl/regfile_scoreboard_sb_counter_bank.sv
// Per-register saturating in-flight write counters.
// Flush and reset clear every counter; busy/full/one are decoded per entry.
module sb_counter_bank #(
  parameter int N = 32,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [N-1:0] inc,
  input  logic [N-1:0] dec,
  output logic [N-1:0] busy,
  output logic [N-1:0] full,
  output logic [N-1:0] one
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt [N];

  // A retire against an empty counter is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int r = 0; r < N; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        unique case ({inc[r], dec[r] && cnt[r] != '0})
          2'b10: if (cnt[r] != MAX) cnt[r] <= cnt[r] + W'(1);
          2'b01: cnt[r] <= cnt[r] - W'(1);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    busy = '0;
    full = '0;
    one  = '0;
    for (int r = 0; r < N; r++) begin
      busy[r] = cnt[r] != '0;
      full[r] = cnt[r] == MAX;
      one[r]  = cnt[r] == W'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with outstanding-write scoreboard and decode stall.
// Optional build macro: RF_WB_BYPASS_EN (writeback-to-decode forwarding).
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);

  reg_data_t regs [NREGS];

  logic      wb_we;
  reg_vec_t  wb_hot;
  logic      iss_ok;
  reg_vec_t  iss_hot;
  reg_vec_t  busy;
  reg_vec_t  full;
  reg_vec_t  one;
  reg_vec_t  busy_eff;
  logic      stall_raw;
  logic      rd_nz;

  assign wb_we  = bus.i_wb_wr_reg_en && bus.i_wb_wr_reg_addr != '0;
  assign wb_hot = wb_we ? onehot(bus.i_wb_wr_reg_addr) : '0;
  assign rd_nz  = bus.i_id_rd_addr != '0;

  assign iss_ok  = bus.i_id_issue && rd_nz && !stall_raw;
  assign iss_hot = iss_ok ? onehot(bus.i_id_rd_addr) : '0;

  sb_counter_bank #(
    .N (NREGS),
    .W (CNTW)
  ) u_sb (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.i_flush),
    .inc   (iss_hot),
    .dec   (wb_hot),
    .busy  (busy),
    .full  (full),
    .one   (one)
  );

`ifdef RF_WB_BYPASS_EN
  // Last pending write landing now is forwarded, so it no longer blocks.
  assign busy_eff = busy & ~(wb_hot & one) & ~reg_vec_t'(1);
`else
  logic unused_one;
  assign unused_one = ^one;
  assign busy_eff   = busy & ~reg_vec_t'(1);
`endif

  assign stall_raw = busy_eff[bus.i_id_rs1_addr]
                   | busy_eff[bus.i_id_rs2_addr]
                   | (bus.i_id_issue && rd_nz
                      && full[bus.i_id_rd_addr]);

  function automatic reg_data_t rd_port(reg_addr_t a);
    reg_data_t d;
    if (a == '0)
      d = '0;
`ifdef RF_WB_BYPASS_EN
    else if (wb_we && a == bus.i_wb_wr_reg_addr)
      d = bus.i_wb_wr_reg_data;
`endif
    else
      d = regs[a];
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (wb_we) begin
      regs[bus.i_wb_wr_reg_addr] <= bus.i_wb_wr_reg_data;
    end
  end

  assign bus.o_id_rs1_data = rst_n ? rd_port(bus.i_id_rs1_addr) : '0;
  assign bus.o_id_rs2_data = rst_n ? rd_port(bus.i_id_rs2_addr) : '0;
  assign bus.o_id_stall    = rst_n && stall_raw;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (both bypass builds).
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if rf ();

  regfile_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf.slave)
  );

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.i_wb_wr_reg_addr = '0;
    rf.i_wb_wr_reg_data = '0;
    rf.i_wb_wr_reg_en   = 1'b0;
    rf.i_id_rs1_addr    = '0;
    rf.i_id_rs2_addr    = '0;
    rf.i_id_issue       = 1'b0;
    rf.i_id_rd_addr     = '0;
    rf.i_flush          = 1'b0;
  endtask

  task automatic iss(input logic [4:0] rd);
    idle();
    rf.i_id_issue   = 1'b1;
    rf.i_id_rd_addr = rd;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    idle();
    rf.i_wb_wr_reg_en   = 1'b1;
    rf.i_wb_wr_reg_addr = a;
    rf.i_wb_wr_reg_data = d;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cyc();
    rf.i_id_rs1_addr = 5'd1;
    #1;
    chk("rst_stall", 32'(rf.o_id_stall), 32'd0);
    chk("rst_rs1", rf.o_id_rs1_data, 32'd0);
    cyc();
    rst_n = 1'b1;
    idle();
    rf.i_id_rs1_addr = 5'd1;
    rf.i_id_rs2_addr = 5'd2;
    #1;
    chk("x1_zero", rf.o_id_rs1_data, 32'd0);
    chk("x2_zero", rf.o_id_rs2_data, 32'd0);
    chk("idle_stall", 32'(rf.o_id_stall), 32'd0);

    // x0 is hardwired
    wb(5'd0, 32'hDEADBEEF);
    #1;
    chk("x0_wr_cyc", rf.o_id_rs1_data, 32'd0);
    cyc();
    idle();
    #1;
    chk("x0_after", rf.o_id_rs1_data, 32'd0);

    // RAW on x5
    iss(5'd5);
    #1;
    chk("x5_iss", 32'(rf.o_id_stall), 32'd0);
    cyc();
    idle();
    rf.i_id_rs1_addr = 5'd5;
    #1;
    chk("x5_raw", 32'(rf.o_id_stall), 32'd1);
    wb(5'd5, 32'h1234);
    rf.i_id_rs1_addr = 5'd5;
    #1;
    chk("x5_wb_stall", 32'(rf.o_id_stall), BYP ? 32'd0 : 32'd1);
    chk("x5_wb_data", rf.o_id_rs1_data, BYP ? 32'h1234 : 32'd0);
    cyc();
    idle();
    rf.i_id_rs1_addr = 5'd5;
    #1;
    chk("x5_nxt_stall", 32'(rf.o_id_stall), 32'd0);
    chk("x5_nxt_data", rf.o_id_rs1_data, 32'h1234);

    // Saturation on x7
    for (int i = 0; i < 3; i++) begin
      iss(5'd7);
      #1;
      chk($sformatf("x7_iss%0d", i), 32'(rf.o_id_stall), 32'd0);
      cyc();
    end
    iss(5'd7);
    #1;
    chk("x7_full", 32'(rf.o_id_stall), 32'd1);
    cyc();
    wb(5'd7, 32'h77);
    cyc();
    iss(5'd7);
    #1;
    chk("x7_after_ret", 32'(rf.o_id_stall), 32'd0);
    cyc();
    iss(5'd7);
    #1;
    chk("x7_full_again", 32'(rf.o_id_stall), 32'd1);
    cyc();

    // Same-cycle issue and retire on x9
    iss(5'd9);
    cyc();
    iss(5'd9);
    rf.i_wb_wr_reg_en   = 1'b1;
    rf.i_wb_wr_reg_addr = 5'd9;
    rf.i_wb_wr_reg_data = 32'h99;
    #1;
    chk("x9_both", 32'(rf.o_id_stall), 32'd0);
    cyc();
    idle();
    rf.i_id_rs2_addr = 5'd9;
    #1;
    chk("x9_busy", 32'(rf.o_id_stall), 32'd1);
    chk("x9_data", rf.o_id_rs2_data, 32'h99);

    // Flush
    iss(5'd3);
    cyc();
    iss(5'd4);
    cyc();
    idle();
    rf.i_flush = 1'b1;
    cyc();
    idle();
    rf.i_id_rs1_addr = 5'd3;
    rf.i_id_rs2_addr = 5'd4;
    #1;
    chk("flush_x3x4", 32'(rf.o_id_stall), 32'd0);
    iss(5'd7);
    #1;
    chk("flush_x7", 32'(rf.o_id_stall), 32'd0);
    iss(5'd4);
    rf.i_flush = 1'b1;
    cyc();
    idle();
    rf.i_id_rs2_addr = 5'd4;
    #1;
    chk("flush_prio", 32'(rf.o_id_stall), 32'd0);
    wb(5'd3, 32'h33);
    cyc();
    idle();
    rf.i_id_rs1_addr = 5'd3;
    #1;
    chk("x3_nostall", 32'(rf.o_id_stall), 32'd0);
    chk("x3_data", rf.o_id_rs1_data, 32'h33);
    for (int i = 0; i < 3; i++) begin
      iss(5'd3);
      #1;
      chk($sformatf("x3_nounder%0d", i), 32'(rf.o_id_stall), 32'd0);
      cyc();
    end
    iss(5'd3);
    #1;
    chk("x3_full", 32'(rf.o_id_stall), 32'd1);
    idle();
    rf.i_flush = 1'b1;
    cyc();

    // Reset mid-operation
    wb(5'd6, 32'hA5);
    cyc();
    iss(5'd6);
    cyc();
    iss(5'd6);
    cyc();
    idle();
    rf.i_id_rs1_addr = 5'd6;
    #1;
    chk("x6_busy", 32'(rf.o_id_stall), 32'd1);
    chk("x6_data", rf.o_id_rs1_data, 32'hA5);
    rst_n = 1'b0;
    #1;
    chk("x6_rst_stall", 32'(rf.o_id_stall), 32'd0);
    chk("x6_rst_data", rf.o_id_rs1_data, 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("x6_post_stall", 32'(rf.o_id_stall), 32'd0);
    chk("x6_post_data", rf.o_id_rs1_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
